pipe_hazard_ctrl: RTL and testbench

- Pipeline control-register chain for the 5-stage MIPS core.
- Decodes the ID-stage instruction and carries opcode/funct/destination through the EX, MEM and WB stage registers.
- Produces the op/funct/op_mem/op_wb bundle consumed by the control path.
- Detects load-use hazards (stall), resolves BEQ in EX and J in ID (flush), and keeps saturating stall/flush event counters.

---
 rtl/pipe_hazard_ctrl.sv | 121 ++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control-register chain for the 5-stage MIPS core: carries decoded
// opcode/funct/destination ID->EX->MEM->WB and raises load-use stall / flush.
module pipe_hazard_ctrl #(
  parameter logic [5:0] BUBBLE_OP = 6'b111111,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      instr_id,
  input  logic             zero,
  output logic [5:0]       op,
  output logic [5:0]       funct,
  output logic [5:0]       op_mem,
  output logic [5:0]       op_wb,
  output logic [4:0]       rs_ex,
  output logic [4:0]       rt_ex,
  output logic [4:0]       dest_wb,
  output logic             stall,
  output logic             flush,
  output logic             branch_taken,
  output logic             jump,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;

  logic [5:0] op_id;
  logic [4:0] rs_id;
  logic [4:0] rt_id;
  logic [4:0] rd_id;
  logic [5:0] funct_id;
  logic [4:0] dest_id;
  logic [4:0] dest_ex;
  logic [4:0] dest_mem;
  logic       rs_match;
  logic       rt_match;
  logic       load_use;
  logic       insert_bubble;

  assign op_id    = instr_id[31:26];
  assign rs_id    = instr_id[25:21];
  assign rt_id    = instr_id[20:16];
  assign rd_id    = instr_id[15:11];
  assign funct_id = instr_id[5:0];

  always_comb begin
    dest_id = 5'd0;
    case (op_id)
      OP_R:           dest_id = rd_id;
      OP_ADDI, OP_LW: dest_id = rt_id;
      default:        dest_id = 5'd0;
    endcase
  end

  // rt is only a true source for R, BEQ and SW; a J has no register sources.
  assign rs_match = (rt_ex == rs_id) && (op_id != OP_J);
  assign rt_match = (rt_ex == rt_id) &&
                    ((op_id == OP_R) || (op_id == OP_BEQ) || (op_id == OP_SW));
  assign load_use = (op == OP_LW) && (rt_ex != 5'd0) && (rs_match || rt_match);

  // A taken branch squashes the ID instruction, so it wins over a stall.
  assign branch_taken  = (op == OP_BEQ) && zero;
  assign stall         = load_use && !branch_taken;
  assign jump          = (op_id == OP_J) && !stall && !branch_taken;
  assign flush         = branch_taken || jump;
  assign insert_bubble = stall || branch_taken;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op      <= BUBBLE_OP;
      funct   <= 6'd0;
      rs_ex   <= 5'd0;
      rt_ex   <= 5'd0;
      dest_ex <= 5'd0;
    end else if (insert_bubble) begin
      op      <= BUBBLE_OP;
      funct   <= 6'd0;
      rs_ex   <= 5'd0;
      rt_ex   <= 5'd0;
      dest_ex <= 5'd0;
    end else begin
      op      <= op_id;
      funct   <= funct_id;
      rs_ex   <= rs_id;
      rt_ex   <= rt_id;
      dest_ex <= dest_id;
    end
  end

  // Downstream stages never stall; they always advance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_mem   <= BUBBLE_OP;
      op_wb    <= BUBBLE_OP;
      dest_mem <= 5'd0;
      dest_wb  <= 5'd0;
    end else begin
      op_mem   <= op;
      op_wb    <= op_mem;
      dest_mem <= dest_ex;
      dest_wb  <= dest_mem;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: pipeline latency, load-use stall,
// branch/jump flush, saturating counters and asynchronous reset.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 4;

  localparam logic [31:0] I_NOPB  = 32'hFC000000; // opcode 111111, no dest
  localparam logic [31:0] I_ADDI5 = 32'h20050003; // ADDI $5,$0,3
  localparam logic [31:0] I_LW2   = 32'h8C220000; // LW $2,0($1)
  localparam logic [31:0] I_ADD   = 32'h00441820; // ADD $3,$2,$4
  localparam logic [31:0] I_BEQ   = 32'h10220004; // BEQ $1,$2,4
  localparam logic [31:0] I_SW    = 32'hAC220000; // SW $2,0($1)
  localparam logic [31:0] I_J     = 32'h08000010; // J 0x10
  localparam logic [31:0] I_J_RS2 = 32'h08400000; // J with bits[25:21]=2
  localparam logic [31:0] I_LW0   = 32'h8C200000; // LW $0,0($1)
  localparam logic [31:0] I_ADD0  = 32'h00001820; // ADD $3,$0,$0
  localparam logic [31:0] I_ADDI2 = 32'h20220005; // ADDI $2,$1,5
  localparam logic [31:0] I_LW22  = 32'h8C420000; // LW $2,0($2)

  logic             clk;
  logic             rst;
  logic [31:0]      instr_id;
  logic             zero;
  logic [5:0]       op;
  logic [5:0]       funct;
  logic [5:0]       op_mem;
  logic [5:0]       op_wb;
  logic [4:0]       rs_ex;
  logic [4:0]       rt_ex;
  logic [4:0]       dest_wb;
  logic             stall;
  logic             flush;
  logic             branch_taken;
  logic             jump;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  int total = 0;
  int bad   = 0;

  pipe_hazard_ctrl #(.BUBBLE_OP(6'b111111), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .instr_id     (instr_id),
    .zero         (zero),
    .op           (op),
    .funct        (funct),
    .op_mem       (op_mem),
    .op_wb        (op_wb),
    .rs_ex        (rs_ex),
    .rt_ex        (rt_ex),
    .dest_wb      (dest_wb),
    .stall        (stall),
    .flush        (flush),
    .branch_taken (branch_taken),
    .jump         (jump),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst      = 1'b0;
    instr_id = I_NOPB;
    zero     = 1'b0;
    #12;
    chk("rst_op",      32'(op),        32'h3F);
    chk("rst_op_mem",  32'(op_mem),    32'h3F);
    chk("rst_op_wb",   32'(op_wb),     32'h3F);
    chk("rst_dest_wb", 32'(dest_wb),   32'h0);
    chk("rst_funct",   32'(funct),     32'h0);
    chk("rst_scnt",    32'(stall_cnt), 32'h0);
    chk("rst_fcnt",    32'(flush_cnt), 32'h0);
    rst = 1'b1;

    // ADDI latency through the stages
    instr_id = I_ADDI5;
    tick();
    chk("addi_op",     32'(op),     32'h08);
    chk("addi_funct",  32'(funct),  32'h03);
    chk("addi_rt_ex",  32'(rt_ex),  32'h05);
    instr_id = I_NOPB;
    tick();
    chk("addi_op_mem", 32'(op_mem), 32'h08);
    chk("nop_op",      32'(op),     32'h3F);
    tick();
    chk("addi_op_wb",  32'(op_wb),  32'h08);
    chk("addi_dest_wb",32'(dest_wb),32'h05);

    // load-use stall, rs match
    instr_id = I_LW2;
    tick();
    chk("lw_op", 32'(op), 32'h23);
    instr_id = I_ADD;
    #1;
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_flush", 32'(flush), 32'h0);
    tick();
    chk("lu_bubble",  32'(op),        32'h3F);
    chk("lu_scnt",    32'(stall_cnt), 32'h1);
    chk("lu_stall_1", 32'(stall),     32'h0);
    tick();
    chk("add_op",     32'(op),      32'h00);
    chk("add_funct",  32'(funct),   32'h20);
    chk("add_rs_ex",  32'(rs_ex),   32'h02);
    chk("add_rt_ex",  32'(rt_ex),   32'h04);
    chk("lw_op_wb",   32'(op_wb),   32'h23);
    chk("lw_dest_wb", 32'(dest_wb), 32'h02);
    chk("bub_op_mem", 32'(op_mem),  32'h3F);

    // BEQ taken
    instr_id = I_BEQ;
    tick();
    chk("beq_op", 32'(op), 32'h04);
    instr_id = I_SW;
    zero = 1'b1;
    #1;
    chk("bt_taken", 32'(branch_taken), 32'h1);
    chk("bt_flush", 32'(flush),        32'h1);
    chk("bt_stall", 32'(stall),        32'h0);
    chk("bt_jump",  32'(jump),         32'h0);
    tick();
    chk("bt_bubble", 32'(op),        32'h3F);
    chk("bt_fcnt",   32'(flush_cnt), 32'h1);
    zero = 1'b0;

    // BEQ not taken
    instr_id = I_BEQ;
    tick();
    instr_id = I_SW;
    zero = 1'b0;
    #1;
    chk("bnt_taken", 32'(branch_taken), 32'h0);
    chk("bnt_flush", 32'(flush),        32'h0);
    tick();
    chk("bnt_sw_op", 32'(op),        32'h2B);
    chk("bnt_fcnt",  32'(flush_cnt), 32'h1);

    // branch beats jump
    instr_id = I_BEQ;
    tick();
    instr_id = I_J;
    zero = 1'b1;
    #1;
    chk("bj_jump",  32'(jump),  32'h0);
    chk("bj_flush", 32'(flush), 32'h1);
    tick();
    zero = 1'b0;
    chk("bj_op",   32'(op),        32'h3F);
    chk("bj_fcnt", 32'(flush_cnt), 32'h2);

    // plain jump
    #1;
    chk("j_jump",  32'(jump),  32'h1);
    chk("j_flush", 32'(flush), 32'h1);
    tick();
    chk("j_op",   32'(op),        32'h02);
    chk("j_fcnt", 32'(flush_cnt), 32'h3);

    // jump after LW whose rt equals the J's bits[25:21]: no stall
    instr_id = I_LW2;
    tick();
    instr_id = I_J_RS2;
    #1;
    chk("jlw_stall", 32'(stall), 32'h0);
    chk("jlw_jump",  32'(jump),  32'h1);
    tick();
    chk("jlw_op",   32'(op),        32'h02);
    chk("jlw_fcnt", 32'(flush_cnt), 32'h4);

    // LW $0 never stalls
    instr_id = I_LW0;
    tick();
    instr_id = I_ADD0;
    #1;
    chk("lw0_stall", 32'(stall), 32'h0);
    tick();
    chk("lw0_add_op", 32'(op), 32'h00);

    // LW $2 then SW $2 (rt match)
    instr_id = I_LW2;
    tick();
    instr_id = I_SW;
    #1;
    chk("sw_stall", 32'(stall), 32'h1);
    tick();
    chk("sw_bubble", 32'(op),        32'h3F);
    chk("sw_scnt",   32'(stall_cnt), 32'h2);
    tick();
    chk("sw_op", 32'(op), 32'h2B);

    // LW $2 then ADDI $2 (rt is a destination)
    instr_id = I_LW2;
    tick();
    instr_id = I_ADDI2;
    #1;
    chk("addi2_stall", 32'(stall), 32'h0);
    tick();
    chk("addi2_op", 32'(op), 32'h08);

    // repeated self-dependent LW: one stall every two cycles, 19 stalls
    instr_id = I_LW22;
    for (int i = 0; i < 38; i++) tick();
    chk("sat_scnt", 32'(stall_cnt), 32'hF);
    chk("sat_fcnt", 32'(flush_cnt), 32'h4);
    tick();
    chk("sat_stall", 32'(stall), 32'h1);
    chk("sat_hold",  32'(stall_cnt), 32'hF);

    // asynchronous reset mid-stall, between clock edges
    #2;
    rst = 1'b0;
    #1;
    chk("arst_op",      32'(op),        32'h3F);
    chk("arst_op_mem",  32'(op_mem),    32'h3F);
    chk("arst_op_wb",   32'(op_wb),     32'h3F);
    chk("arst_rt_ex",   32'(rt_ex),     32'h0);
    chk("arst_dest_wb", 32'(dest_wb),   32'h0);
    chk("arst_scnt",    32'(stall_cnt), 32'h0);
    chk("arst_fcnt",    32'(flush_cnt), 32'h0);
    chk("arst_stall",   32'(stall),     32'h0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
